tt_sweep_checker: RTL

TT_SWEEP_CHECKER -- requirements
Module: tt_sweep_checker

---
 rtl/tt_check_pkg.sv | 16 +
 rtl/tt_vec_gen.sv | 57 +++++
 rtl/tt_sweep_checker.sv | 111 +++++++++++
 3 files changed

// File: rtl/tt_check_pkg.sv
// Shared types and sizes for the truth-table sweep checker.
// The FSM state encoding lives here so the checker and its bench agree on it.
package tt_check_pkg;

    localparam int VEC_W   = 4;
    localparam int NUM_VEC = 16;
    localparam int ERR_W   = 5;
    localparam int HOLD_W  = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DRIVE = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/tt_vec_gen.sv
// Vector counter and settle timer for the sweep checker.
// Each vector is held for SETTLE+1 cycles, and the sample strobe marks the last cycle of that hold.
module tt_vec_gen
    import tt_check_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    output logic [VEC_W-1:0] vec,
    output logic             sample,
    output logic             last
);

    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(SETTLE);
    localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(NUM_VEC - 1);

    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    // After the final vector, the counter returns to 0 so the outputs idle at 0000.
    always_comb begin
        vec_d  = vec_q;
        hold_d = hold_q;
        sample = run && (hold_q == '0);
        last   = sample && (vec_q == VEC_LAST);
        if (load) begin
            vec_d  = '0;
            hold_d = HOLD_INIT;
        end else if (sample) begin
            if (last) begin
                vec_d  = '0;
                hold_d = '0;
            end else begin
                vec_d  = vec_q + 1'b1;
                hold_d = HOLD_INIT;
            end
        end else if (run) begin
            hold_d = hold_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q  <= '0;
            hold_q <= '0;
        end else begin
            vec_q  <= vec_d;
            hold_q <= hold_d;
        end
    end

    assign vec = vec_q;

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all 16 input vectors of a 4-input device and compares each response with EXPECTED.
// Reports the error count and the first failing vector; every output comes from a register.
module tt_sweep_checker
    import tt_check_pkg::*;
#(
    parameter logic [NUM_VEC-1:0] EXPECTED = 16'h0000,
    parameter int                 SETTLE   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    input  logic             f2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic             first_fail_valid
);

    state_t           state_q, state_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [VEC_W-1:0] first_fail_vec_q, first_fail_vec_d;
    logic             first_fail_valid_q, first_fail_valid_d;
    logic             armed_q, armed_d;

    logic [VEC_W-1:0] vec;
    logic             sample;
    logic             last;
    logic             accept;
    logic             run;
    logic             mismatch;

    // A start pulse is ignored on the first edge after reset, because armed_q is still low then.
    assign run      = (state_q == ST_DRIVE);
    assign accept   = start && armed_q && !run;
    assign mismatch = sample && (f2 != EXPECTED[vec]);

    tt_vec_gen #(
        .SETTLE (SETTLE)
    ) u_vec_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .run    (run),
        .vec    (vec),
        .sample (sample),
        .last   (last)
    );

    always_comb begin
        state_d            = state_q;
        err_count_d        = err_count_q;
        first_fail_vec_d   = first_fail_vec_q;
        first_fail_valid_d = first_fail_valid_q;
        armed_d            = 1'b1;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d            = ST_DRIVE;
                    err_count_d        = '0;
                    first_fail_valid_d = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (mismatch) begin
                    if (err_count_q != ERR_W'(NUM_VEC)) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                    if (!first_fail_valid_q) begin
                        first_fail_vec_d   = vec;
                        first_fail_valid_d = 1'b1;
                    end
                end
                if (last) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= ST_IDLE;
            err_count_q        <= '0;
            first_fail_vec_q   <= '0;
            first_fail_valid_q <= 1'b0;
            armed_q            <= 1'b0;
        end else begin
            state_q            <= state_d;
            err_count_q        <= err_count_d;
            first_fail_vec_q   <= first_fail_vec_d;
            first_fail_valid_q <= first_fail_valid_d;
            armed_q            <= armed_d;
        end
    end

    assign {a, b, c, d}     = vec;
    assign busy             = run;
    assign done             = (state_q == ST_DONE);
    assign pass             = done && (err_count_q == '0);
    assign err_count        = err_count_q;
    assign first_fail_vec   = first_fail_vec_q;
    assign first_fail_valid = first_fail_valid_q;

endmodule
